// File: rtl/status_reply_tx.sv
// status_reply_tx: reports changes of the gripper run/stop level to the host
// as ASCII "RUN\r\n" / "HALT\r\n" on an 8N1 UART line.
module status_reply_tx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic CLK,
    input  logic RESET,
    input  logic Start_signal,
    output logic TX,
    output logic Busy,
    output logic Msg_done
);
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] BAUD_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] BAUD_ONE  = CNT_W'(1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    localparam logic MSG_HALT = 1'b0;
    localparam logic MSG_RUN  = 1'b1;

    // Constant message table: msg selects RUN/HALT, idx selects the byte.
    function automatic logic [7:0] msg_byte(input logic msg, input logic [2:0] idx);
        logic [7:0] b;
        b = 8'h00;
        if (msg == MSG_RUN) begin
            case (idx)
                3'd0:    b = 8'h52;
                3'd1:    b = 8'h55;
                3'd2:    b = 8'h4E;
                3'd3:    b = 8'h0D;
                3'd4:    b = 8'h0A;
                default: b = 8'h00;
            endcase
        end else begin
            case (idx)
                3'd0:    b = 8'h48;
                3'd1:    b = 8'h41;
                3'd2:    b = 8'h4C;
                3'd3:    b = 8'h54;
                3'd4:    b = 8'h0D;
                3'd5:    b = 8'h0A;
                default: b = 8'h00;
            endcase
        end
        return b;
    endfunction

    logic             s_q_r;
    logic             rep_r;
    logic             msg_sel_r;
    logic [1:0]       state_r;
    logic [CNT_W-1:0] baud_cnt_r;
    logic [2:0]       bit_idx_r;
    logic [2:0]       byte_idx_r;

    logic [7:0]       cur_byte_s;
    logic [2:0]       bit_next_s;
    logic             baud_end_s;
    logic             last_byte_s;

    // Current byte, next data bit index and bit/byte boundary flags.
    always_comb begin
        cur_byte_s  = msg_byte(msg_sel_r, byte_idx_r);
        bit_next_s  = bit_idx_r + 3'd1;
        baud_end_s  = (baud_cnt_r == BAUD_LAST);
        last_byte_s = (byte_idx_r == ((msg_sel_r == MSG_RUN) ? 3'd4 : 3'd5));
    end

    // Message sequencer and 8N1 serializer; TX is loaded one edge ahead so it is registered.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            s_q_r      <= 1'b0;
            rep_r      <= 1'b0;
            msg_sel_r  <= MSG_HALT;
            state_r    <= ST_IDLE;
            baud_cnt_r <= BAUD_ZERO;
            bit_idx_r  <= 3'd0;
            byte_idx_r <= 3'd0;
            TX         <= 1'b1;
            Busy       <= 1'b0;
            Msg_done   <= 1'b0;
        end else begin
            s_q_r    <= Start_signal;
            Msg_done <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    baud_cnt_r <= BAUD_ZERO;
                    bit_idx_r  <= 3'd0;
                    byte_idx_r <= 3'd0;
                    TX         <= 1'b1;
                    Busy       <= 1'b0;
                    // Only the latest level matters; edges seen while busy collapse here.
                    if (s_q_r != rep_r) begin
                        msg_sel_r <= s_q_r;
                        rep_r     <= s_q_r;
                        state_r   <= ST_START;
                        TX        <= 1'b0;
                        Busy      <= 1'b1;
                    end
                end
                ST_START: begin
                    if (baud_end_s) begin
                        baud_cnt_r <= BAUD_ZERO;
                        state_r    <= ST_DATA;
                        TX         <= cur_byte_s[0];
                    end else begin
                        baud_cnt_r <= baud_cnt_r + BAUD_ONE;
                    end
                end
                ST_DATA: begin
                    if (baud_end_s) begin
                        baud_cnt_r <= BAUD_ZERO;
                        if (bit_idx_r == 3'd7) begin
                            bit_idx_r <= 3'd0;
                            state_r   <= ST_STOP;
                            TX        <= 1'b1;
                        end else begin
                            bit_idx_r <= bit_next_s;
                            TX        <= cur_byte_s[bit_next_s];
                        end
                    end else begin
                        baud_cnt_r <= baud_cnt_r + BAUD_ONE;
                    end
                end
                ST_STOP: begin
                    if (baud_end_s) begin
                        baud_cnt_r <= BAUD_ZERO;
                        if (last_byte_s) begin
                            byte_idx_r <= 3'd0;
                            state_r    <= ST_IDLE;
                            TX         <= 1'b1;
                            Busy       <= 1'b0;
                            Msg_done   <= 1'b1;
                        end else begin
                            byte_idx_r <= byte_idx_r + 3'd1;
                            state_r    <= ST_START;
                            TX         <= 1'b0;
                        end
                    end else begin
                        baud_cnt_r <= baud_cnt_r + BAUD_ONE;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    baud_cnt_r <= BAUD_ZERO;
                    bit_idx_r  <= 3'd0;
                    byte_idx_r <= 3'd0;
                    TX         <= 1'b1;
                    Busy       <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_status_reply_tx.sv
// Testbench for status_reply_tx: three instances (4, 2 and 868 clocks per bit)
// checked by a UART frame decoder, a vector table and a text-level line model.
module tb_status_reply_tx;
    logic       CLK = 1'b0;
    logic [2:0] rst_v;
    logic [2:0] st_v;
    logic       tx0, tx1, tx2, busy0, busy1, busy2, done0, done1, done2;
    logic [2:0] tx_v, busy_v, done_v;
    int         n_tests = 0;
    int         n_fail  = 0;

    assign tx_v   = {tx2, tx1, tx0};
    assign busy_v = {busy2, busy1, busy0};
    assign done_v = {done2, done1, done0};

    always #5 CLK = ~CLK;

    status_reply_tx #(.CLKS_PER_BIT(4)) u_dut4 (
        .CLK(CLK), .RESET(rst_v[0]), .Start_signal(st_v[0]),
        .TX(tx0), .Busy(busy0), .Msg_done(done0));
    status_reply_tx #(.CLKS_PER_BIT(2)) u_dut2 (
        .CLK(CLK), .RESET(rst_v[1]), .Start_signal(st_v[1]),
        .TX(tx1), .Busy(busy1), .Msg_done(done1));
    status_reply_tx #(.CLKS_PER_BIT(868)) u_dut868 (
        .CLK(CLK), .RESET(rst_v[2]), .Start_signal(st_v[2]),
        .TX(tx2), .Busy(busy2), .Msg_done(done2));

    function automatic int cpb_of(input int k);
        case (k)
            0:       return 4;
            1:       return 2;
            default: return 868;
        endcase
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Called at a negedge. Waits for a start bit (or checks the line stays quiet when
    // exp is empty), decodes every frame, and returns at the negedge after Busy falls.
    task automatic expect_msg(input int k, input string name, input string exp,
                              input int wait_max, input int exp_lat);
        int         n, idle_bad, bad, ctl_bad, frames, cpb;
        logic [7:0] got[$];
        logic [9:0] fr;
        logic       bv;
        cpb = cpb_of(k);
        n = 0; idle_bad = 0; bad = 0; ctl_bad = 0; frames = 0;
        do begin
            @(negedge CLK);
            n++;
            if (tx_v[k] === 1'b1 && (busy_v[k] !== 1'b0 || done_v[k] !== 1'b0)) idle_bad++;
        end while (tx_v[k] !== 1'b0 && n < wait_max);
        chk({name, "_idle_ctl"}, idle_bad, 0);
        if (exp.len() == 0) begin
            chk({name, "_quiet_tx"}, int'(tx_v[k]), 1);
            return;
        end
        chk({name, "_start_seen"}, int'(tx_v[k]), 0);
        if (tx_v[k] !== 1'b0) return;
        if (exp_lat > 0) chk({name, "_latency"}, n, exp_lat);
        do begin
            for (int b = 0; b < 10; b++) begin
                bv = tx_v[k];
                for (int c = 0; c < cpb; c++) begin
                    if (tx_v[k] !== bv) bad++;
                    if (busy_v[k] !== 1'b1 || done_v[k] !== 1'b0) ctl_bad++;
                    @(negedge CLK);
                end
                fr[b] = bv;
            end
            if (fr[0] !== 1'b0 || fr[9] !== 1'b1) bad++;
            got.push_back(fr[8:1]);
            frames++;
        end while (tx_v[k] === 1'b0 && frames < 8);
        chk({name, "_len"}, got.size(), exp.len());
        for (int i = 0; i < got.size() && i < exp.len(); i++)
            chk($sformatf("%s_byte%0d", name, i), int'(got[i]), int'(exp[i]));
        chk({name, "_bit_timing"}, bad, 0);
        chk({name, "_busy_high"}, ctl_bad, 0);
        chk({name, "_busy_fall"}, int'(busy_v[k]), 0);
        chk({name, "_done_pulse"}, int'(done_v[k]), 1);
        chk({name, "_tx_idle"}, int'(tx_v[k]), 1);
    endtask

    // Random level changes and rare resets, compared every cycle against a model
    // that expands each message text into its serial bit stream.
    task automatic rand_run(input int k, input int ncyc);
        int         cpb, mism;
        bit         m_rep, m_sq, m_pend, lvl, do_rst, etx, ebusy, edone, bv;
        bit         q[$];
        string      txt;
        logic [7:0] ch;
        cpb = cpb_of(k);
        m_rep = 1'b0; m_sq = 1'b0; m_pend = 1'b0; mism = 0; lvl = st_v[k];
        etx = 1'b1; ebusy = 1'b0; edone = 1'b0;
        for (int e = 0; e < ncyc; e++) begin
            do_rst = (e == 0) || ($urandom_range(0, 1499) == 0);
            if ($urandom_range(0, 99) == 0) lvl = ~lvl;
            rst_v[k] = do_rst;
            st_v[k]  = lvl;
            if (do_rst) begin
                q.delete();
                m_rep = 1'b0; m_sq = 1'b0; m_pend = 1'b0;
                etx = 1'b1; ebusy = 1'b0; edone = 1'b0;
            end else begin
                if (q.size() > 0) begin
                    etx = q.pop_front(); ebusy = 1'b1; edone = 1'b0;
                    if (q.size() == 0) m_pend = 1'b1;
                end else if (m_pend) begin
                    etx = 1'b1; ebusy = 1'b0; edone = 1'b1; m_pend = 1'b0;
                end else if (m_sq != m_rep) begin
                    txt = m_sq ? "RUN\r\n" : "HALT\r\n";
                    for (int i = 0; i < txt.len(); i++) begin
                        ch = txt[i];
                        for (int b = 0; b < 10; b++) begin
                            bv = (b == 0) ? 1'b0 : ((b == 9) ? 1'b1 : ch[b-1]);
                            repeat (cpb) q.push_back(bv);
                        end
                    end
                    m_rep = m_sq;
                    etx = q.pop_front(); ebusy = 1'b1; edone = 1'b0;
                end else begin
                    etx = 1'b1; ebusy = 1'b0; edone = 1'b0;
                end
                m_sq = lvl;
            end
            @(negedge CLK);
            if (tx_v[k] !== etx || busy_v[k] !== ebusy || done_v[k] !== edone) begin
                if (mism == 0)
                    $display("[TB] rand k=%0d first divergence at step %0d: tx/busy/done=%b%b%b model=%b%b%b",
                             k, e, tx_v[k], busy_v[k], done_v[k], etx, ebusy, edone);
                mism++;
            end
        end
        rst_v[k] = 1'b0;
        chk($sformatf("rand_k%0d_cycles", k), mism, 0);
    endtask

    typedef struct {
        bit    lvl;
        string msg;
    } vec_t;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[6];
        tbl[0] = '{lvl: 1'b1, msg: "RUN\r\n"};
        tbl[1] = '{lvl: 1'b0, msg: "HALT\r\n"};
        tbl[2] = '{lvl: 1'b0, msg: ""};
        tbl[3] = '{lvl: 1'b1, msg: "RUN\r\n"};
        tbl[4] = '{lvl: 1'b1, msg: ""};
        tbl[5] = '{lvl: 1'b0, msg: "HALT\r\n"};

        rst_v = 3'b111;
        st_v  = 3'b000;
        @(negedge CLK);
        chk("reset_tx", int'(tx0), 1);
        chk("reset_busy", int'(busy0), 0);
        chk("reset_done", int'(done0), 0);
        @(negedge CLK);
        rst_v = 3'b000;

        // Idle after reset with the level low: nothing is sent.
        expect_msg(0, "reset_idle", "", 200, 0);

        for (int i = 0; i < 6; i++) begin
            st_v[0] = tbl[i].lvl;
            expect_msg(0, $sformatf("vec%0d", i), tbl[i].msg,
                       (tbl[i].msg.len() == 0) ? 300 : 10, 2);
        end

        // 1->0 during RUN: full RUN, one idle cycle, then HALT.
        st_v[0] = 1'b1;
        fork
            expect_msg(0, "mid1_run", "RUN\r\n", 10, 2);
            begin
                repeat (22) @(negedge CLK);
                st_v[0] = 1'b0;
            end
        join
        expect_msg(0, "mid1_halt", "HALT\r\n", 10, 1);

        // 1->0->1 during RUN: RUN only.
        st_v[0] = 1'b1;
        fork
            expect_msg(0, "mid2_run", "RUN\r\n", 10, 2);
            begin
                repeat (22) @(negedge CLK);
                st_v[0] = 1'b0;
                repeat (20) @(negedge CLK);
                st_v[0] = 1'b1;
            end
        join
        expect_msg(0, "mid2_quiet", "", 300, 0);

        // Reset during the start bit of byte 2 of a RUN.
        st_v[0] = 1'b0;
        expect_msg(0, "pre_rst_halt", "HALT\r\n", 10, 2);
        st_v[0] = 1'b1;
        repeat (2) @(negedge CLK);
        chk("rst_run_started", int'(tx0), 0);
        repeat (80) @(negedge CLK);
        chk("rst_byte2_start_tx", int'(tx0), 0);
        chk("rst_byte2_busy", int'(busy0), 1);
        rst_v[0] = 1'b1;
        #1;
        chk("rst_async_tx", int'(tx0), 1);
        chk("rst_async_busy", int'(busy0), 0);
        chk("rst_async_done", int'(done0), 0);
        @(negedge CLK);
        rst_v[0] = 1'b0;
        expect_msg(0, "post_rst_run", "RUN\r\n", 10, 2);

        rand_run(0, 4000);

        // Parameter sweep.
        st_v[1] = 1'b1;
        expect_msg(1, "cpb2_run", "RUN\r\n", 10, 2);
        rand_run(1, 3000);
        st_v[2] = 1'b1;
        expect_msg(2, "cpb868_run", "RUN\r\n", 10, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
